// File: rtl/dist6_3_if.sv
// Handshake bundle for the 3-way distributor: one input stream, three output channels.
interface dist6_3_if #(
  parameter int unsigned WIDTH = 6
);
  logic             E;
  logic             MODE;
  logic             A;
  logic             B;
  logic             C;
  logic [WIDTH-1:0] D;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] P0;
  logic [WIDTH-1:0] P1;
  logic [WIDTH-1:0] P2;
  logic             V0;
  logic             V1;
  logic             V2;
  logic             R0;
  logic             R1;
  logic             R2;
  logic [2:0]       SEL;
  logic             ERR;

  modport master (
    output E, MODE, A, B, C, D, IN_VALID, R0, R1, R2,
    input  IN_READY, P0, P1, P2, V0, V1, V2, SEL, ERR
  );

  modport slave (
    input  E, MODE, A, B, C, D, IN_VALID, R0, R1, R2,
    output IN_READY, P0, P1, P2, V0, V1, V2, SEL, ERR
  );
endinterface

// File: rtl/dist6_3.sv
// 6-bit, 3-way distributor: routes each accepted word into one of three one-entry
// channel slots, chosen by a one-hot {A,B,C} code or by a round-robin pointer.
module dist6_3 #(
  parameter int unsigned WIDTH = 6
) (
  input  logic      CLK,
  input  logic      RST_N,
  dist6_3_if.slave  bus
);

  localparam int unsigned NCH = 3;
  localparam int unsigned PW  = 2;

  logic [WIDTH-1:0] p_q [NCH];
  logic [WIDTH-1:0] p_d [NCH];
  logic [NCH-1:0]   v_q, v_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [2:0]       sel_q, sel_d;
  logic             err_q, err_d;

  logic [2:0]       code;
  logic [NCH-1:0]   rdy;
  logic [NCH-1:0]   avail;
  logic [PW-1:0]    tgt;
  logic             code_ok;
  logic             ready_c;
  logic             accept;
  logic             load_ok;

  assign code  = {bus.A, bus.B, bus.C};
  assign rdy   = {bus.R2, bus.R1, bus.R0};
  // A full slot that drains this cycle can take a new word on the same edge.
  assign avail = ~v_q | rdy;

  // Target selection; invalid explicit codes are flagged rather than routed.
  always_comb begin
    tgt     = ptr_q;
    code_ok = 1'b1;
    if (!bus.MODE) begin
      case (code)
        3'b100:  tgt = PW'(0);
        3'b010:  tgt = PW'(1);
        3'b001:  tgt = PW'(2);
        default: begin
          tgt     = PW'(0);
          code_ok = 1'b0;
        end
      endcase
    end
  end

  assign ready_c = bus.E & (~code_ok | avail[tgt]);
  assign accept  = bus.IN_VALID & ready_c;
  assign load_ok = accept & code_ok;

  // Next-state for slots, pointer and status.
  always_comb begin
    ptr_d = ptr_q;
    sel_d = sel_q;
    err_d = err_q;
    v_d   = v_q;
    for (int n = 0; n < NCH; n++) begin
      p_d[n] = p_q[n];
      if (load_ok && (tgt == PW'(n))) begin
        p_d[n] = bus.D;
        v_d[n] = 1'b1;
      end else if (v_q[n] && rdy[n]) begin
        p_d[n] = '0;
        v_d[n] = 1'b0;
      end
    end
    if (load_ok && bus.MODE) begin
      ptr_d = (ptr_q == PW'(2)) ? PW'(0) : PW'(ptr_q + PW'(1));
    end
    if (accept) begin
      sel_d = code_ok ? 3'(3'b100 >> tgt) : 3'b000;
      err_d = err_q | ~code_ok;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int n = 0; n < NCH; n++) begin
        p_q[n] <= '0;
      end
      v_q   <= '0;
      ptr_q <= '0;
      sel_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        p_q[n] <= p_d[n];
      end
      v_q   <= v_d;
      ptr_q <= ptr_d;
      sel_q <= sel_d;
      err_q <= err_d;
    end
  end

  assign bus.IN_READY = ready_c;
  assign bus.P0       = p_q[0];
  assign bus.P1       = p_q[1];
  assign bus.P2       = p_q[2];
  assign bus.V0       = v_q[0];
  assign bus.V1       = v_q[1];
  assign bus.V2       = v_q[2];
  assign bus.SEL      = sel_q;
  assign bus.ERR      = err_q;

endmodule

// File: tb/tb_dist6_3.sv
// Directed bench for dist6_3: explicit routing, back-pressure, invalid codes,
// round-robin order and blocking, enable gating and asynchronous reset.
module tb_dist6_3;

  logic CLK;
  logic RST_N;
  int   total;
  int   bad;

  dist6_3_if #(.WIDTH(6)) dif ();

  dist6_3 #(.WIDTH(6)) u_dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (dif.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_code(input logic [2:0] c);
    {dif.A, dif.B, dif.C} = c;
  endtask

  task automatic set_r(input logic [2:0] r);
    {dif.R2, dif.R1, dif.R0} = r;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    dif.E = 1'b0; dif.MODE = 1'b0; set_code(3'b000);
    dif.D = '0; dif.IN_VALID = 1'b0; set_r(3'b000);
    step(); step();
    total++; if ({dif.V0, dif.V1, dif.V2} !== 3'b000) begin bad++; $display("FAIL reset_v got=%b want=000", {dif.V0, dif.V1, dif.V2}); end
    total++; if ({dif.P0, dif.P1, dif.P2} !== 18'h0) begin bad++; $display("FAIL reset_p got=%h want=0", {dif.P0, dif.P1, dif.P2}); end
    total++; if ({dif.SEL, dif.ERR} !== 4'b0000) begin bad++; $display("FAIL reset_sel_err got=%b want=0000", {dif.SEL, dif.ERR}); end
    RST_N = 1'b1;
  endtask

  task automatic test_explicit();
    dif.E = 1'b1; dif.MODE = 1'b0; set_code(3'b010); dif.D = 6'h2A; dif.IN_VALID = 1'b1; set_r(3'b000);
    #1;
    total++; if (dif.IN_READY !== 1'b1) begin bad++; $display("FAIL exp_ready got=%b want=1", dif.IN_READY); end
    step();
    total++; if ({dif.V0, dif.V1, dif.V2} !== 3'b010) begin bad++; $display("FAIL exp_v got=%b want=010", {dif.V0, dif.V1, dif.V2}); end
    total++; if (dif.P1 !== 6'h2A) begin bad++; $display("FAIL exp_p1 got=%h want=2a", dif.P1); end
    total++; if ({dif.P0, dif.P2} !== 12'h0) begin bad++; $display("FAIL exp_p0p2 got=%h want=0", {dif.P0, dif.P2}); end
    total++; if (dif.SEL !== 3'b010) begin bad++; $display("FAIL exp_sel got=%b want=010", dif.SEL); end
    // second word while channel 1 is held
    dif.D = 6'h15;
    #1;
    total++; if (dif.IN_READY !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", dif.IN_READY); end
    step();
    total++; if ({dif.V1, dif.P1} !== {1'b1, 6'h2A}) begin bad++; $display("FAIL hold_p1 got=%h want=6a", {dif.V1, dif.P1}); end
    set_r(3'b010);
    #1;
    total++; if (dif.IN_READY !== 1'b1) begin bad++; $display("FAIL pass_ready got=%b want=1", dif.IN_READY); end
    step();
    total++; if ({dif.V1, dif.P1} !== {1'b1, 6'h15}) begin bad++; $display("FAIL pass_p1 got=%h want=55", {dif.V1, dif.P1}); end
    dif.IN_VALID = 1'b0;
    step();
    total++; if ({dif.V1, dif.P1} !== 7'h00) begin bad++; $display("FAIL drain_p1 got=%h want=00", {dif.V1, dif.P1}); end
  endtask

  task automatic test_invalid();
    set_code(3'b110); dif.IN_VALID = 1'b1; set_r(3'b000); dif.D = 6'h33;
    #1;
    total++; if (dif.IN_READY !== 1'b1) begin bad++; $display("FAIL inv_ready got=%b want=1", dif.IN_READY); end
    step();
    total++; if ({dif.ERR, dif.SEL} !== 4'b1000) begin bad++; $display("FAIL inv_err_sel got=%b want=1000", {dif.ERR, dif.SEL}); end
    total++; if ({dif.V0, dif.V1, dif.V2} !== 3'b000) begin bad++; $display("FAIL inv_v got=%b want=000", {dif.V0, dif.V1, dif.V2}); end
    dif.IN_VALID = 1'b0;
    step();
    total++; if (dif.ERR !== 1'b1) begin bad++; $display("FAIL inv_sticky got=%b want=1", dif.ERR); end
  endtask

  task automatic test_round_robin();
    logic [5:0] pexp [4];
    logic [2:0] sexp [4];
    logic [2:0] vexp [4];
    pexp = '{6'h01, 6'h02, 6'h03, 6'h04};
    sexp = '{3'b100, 3'b010, 3'b001, 3'b100};
    vexp = '{3'b100, 3'b010, 3'b001, 3'b100};
    dif.MODE = 1'b1; set_code(3'b110); set_r(3'b111); dif.IN_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dif.D = 6'(i + 1);
      step();
      total++;
      if ({dif.V0, dif.V1, dif.V2, dif.SEL} !== {vexp[i], sexp[i]} ||
          (dif.P0 | dif.P1 | dif.P2) !== pexp[i]) begin
        bad++;
        $display("FAIL rr_word%0d got v=%b sel=%b p=%h/%h/%h want v=%b sel=%b p=%h",
                 i, {dif.V0, dif.V1, dif.V2}, dif.SEL, dif.P0, dif.P1, dif.P2, vexp[i], sexp[i], pexp[i]);
      end
    end
    dif.IN_VALID = 1'b0;
    step();
    total++; if ({dif.V0, dif.V1, dif.V2} !== 3'b000) begin bad++; $display("FAIL rr_idle_v got=%b want=000", {dif.V0, dif.V1, dif.V2}); end
  endtask

  task automatic test_rr_block();
    // pointer is at channel 1; bring it back to 0 with channel 0 stuck full
    set_r(3'b110); dif.IN_VALID = 1'b1;
    for (int i = 5; i <= 9; i++) begin
      dif.D = 6'(i);
      step();
    end
    total++; if ({dif.V0, dif.P0} !== {1'b1, 6'h07}) begin bad++; $display("FAIL blk_setup got=%h want=47", {dif.V0, dif.P0}); end
    dif.D = 6'h0A;
    #1;
    total++; if (dif.IN_READY !== 1'b0) begin bad++; $display("FAIL blk_ready got=%b want=0", dif.IN_READY); end
    step();
    total++; if ({dif.V0, dif.V1, dif.V2, dif.P0, dif.SEL} !== {3'b100, 6'h07, 3'b001}) begin
      bad++; $display("FAIL blk_hold got v=%b p0=%h sel=%b want v=100 p0=07 sel=001", {dif.V0, dif.V1, dif.V2}, dif.P0, dif.SEL);
    end
    set_r(3'b111);
    #1;
    total++; if (dif.IN_READY !== 1'b1) begin bad++; $display("FAIL blk_release_ready got=%b want=1", dif.IN_READY); end
    step();
    total++; if ({dif.V0, dif.V1, dif.P0, dif.SEL} !== {2'b10, 6'h0A, 3'b100}) begin
      bad++; $display("FAIL blk_release got v0v1=%b p0=%h sel=%b want 10 0a 100", {dif.V0, dif.V1}, dif.P0, dif.SEL);
    end
  endtask

  task automatic test_enable_reset();
    dif.E = 1'b0; dif.IN_VALID = 1'b1; dif.D = 6'h3F; set_r(3'b001);
    #1;
    total++; if (dif.IN_READY !== 1'b0) begin bad++; $display("FAIL en_ready got=%b want=0", dif.IN_READY); end
    step();
    total++; if ({dif.V0, dif.V1, dif.V2, dif.P0, dif.SEL} !== {3'b000, 6'h00, 3'b100}) begin
      bad++; $display("FAIL en_drain got v=%b p0=%h sel=%b want 000 00 100", {dif.V0, dif.V1, dif.V2}, dif.P0, dif.SEL);
    end
    dif.E = 1'b1; set_r(3'b000); dif.D = 6'h11;
    step();
    total++; if ({dif.V0, dif.V1, dif.V2, dif.P1} !== {3'b010, 6'h11}) begin
      bad++; $display("FAIL pre_rst got v=%b p1=%h want 010 11", {dif.V0, dif.V1, dif.V2}, dif.P1);
    end
    dif.IN_VALID = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    total++; if ({dif.V0, dif.V1, dif.V2, dif.SEL, dif.ERR} !== 7'h00) begin
      bad++; $display("FAIL async_rst_flags got=%b want=0000000", {dif.V0, dif.V1, dif.V2, dif.SEL, dif.ERR});
    end
    total++; if ({dif.P0, dif.P1, dif.P2} !== 18'h0) begin bad++; $display("FAIL async_rst_p got=%h want=0", {dif.P0, dif.P1, dif.P2}); end
    step();
    RST_N = 1'b1;
    dif.MODE = 1'b1; dif.IN_VALID = 1'b1; dif.D = 6'h22;
    #1;
    total++; if (dif.IN_READY !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", dif.IN_READY); end
    step();
    total++; if ({dif.V0, dif.V1, dif.V2, dif.P0, dif.SEL} !== {3'b100, 6'h22, 3'b100}) begin
      bad++; $display("FAIL post_rst_rr got v=%b p0=%h sel=%b want 100 22 100", {dif.V0, dif.V1, dif.V2}, dif.P0, dif.SEL);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_explicit();
    test_invalid();
    test_round_robin();
    test_rr_block();
    test_enable_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
